// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX line arbiter.
//   arb_state_e    : arbiter FSM state (idle / line locked)
//   uart_byte_t    : one byte on the UART byte interface
//   UART_LINE_TERM : default byte that ends a line and releases the lock
package uart_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  typedef logic [7:0] uart_byte_t;

  localparam byte UART_LINE_TERM = 8'h0A;

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin priority picker.
// Grants the first set request bit at or after ptr, wrapping NumReq-1 -> 0.
// Ports:
//   req       : request vector
//   ptr       : index with the highest priority this round
//   gnt_valid : some request bit is set
//   gnt_idx   : index of the granted request (0 when gnt_valid is 0)
module uart_arb_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0]         req,
  input  logic [$clog2(NumReq)-1:0] ptr,
  output logic                      gnt_valid,
  output logic [$clog2(NumReq)-1:0] gnt_idx
);

  localparam int unsigned IdxW = $clog2(NumReq);

  always_comb begin
    logic [IdxW-1:0] cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(ptr) + i) % NumReq);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_line_arbiter.sv
// Shares one UART TX serializer between NumReq byte-stream requesters.
// Grants are round-robin and line-locked: the owner keeps the UART until it
// sends LineTerm, so printed lines from different requesters never interleave.
// Optional feature macro: UART_ARB_TIMEOUT_EN -- releases a lock whose owner
// has been idle for TimeoutCycles cycles.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_valid_i  : per-requester byte valid
//   req_data_i   : per-requester byte, requester r at [r*8 +: 8]
//   req_ready_o  : per-requester byte accepted
//   tx_valid_o   : byte to UART serializer valid
//   tx_data_o    : byte to UART serializer
//   tx_ready_i   : UART serializer accepts byte
//   owner_o      : index of current (or last) lock owner
//   busy_o       : lock held
module uart_tx_line_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NumReq        = 4,
  parameter uart_byte_t  LineTerm      = UART_LINE_TERM,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_valid_i,
  input  logic [NumReq*8-1:0]       req_data_i,
  output logic [NumReq-1:0]         req_ready_o,
  output logic                      tx_valid_o,
  output logic [7:0]                tx_data_o,
  input  logic                      tx_ready_i,
  output logic [$clog2(NumReq)-1:0] owner_o,
  output logic                      busy_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  arb_state_e      state_q;
  logic [IdxW-1:0] owner_q;
  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] owner_next;
  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;
  logic            owner_valid;
  uart_byte_t      owner_data;
  logic            lock_active;
  logic            accept;
  logic            release_term;
  logic            release_timeout;
  uart_byte_t      req_bytes [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign req_bytes[g] = req_data_i[g*8 +: 8];
  end

  uart_arb_rr_pick #(
    .NumReq (NumReq)
  ) u_rr_pick (
    .req       (req_valid_i),
    .ptr       (ptr_q),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  assign owner_valid = req_valid_i[owner_q];
  assign owner_data  = req_bytes[owner_q];
  assign owner_next  = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + 1'b1;

  // Pass-through is masked while rst_i is high so a byte offered in the
  // reset cycle is never handshaken; the lock is dropped at that edge anyway.
  assign lock_active  = (state_q == ARB_LOCKED) && !rst_i;
  assign accept       = lock_active && owner_valid && tx_ready_i;
  assign release_term = accept && (owner_data == LineTerm);

  always_comb begin
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;
    if (lock_active) begin
      tx_valid_o           = owner_valid;
      tx_data_o            = owner_data;
      req_ready_o[owner_q] = tx_ready_i;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  logic [CntW-1:0] idle_cnt_q;

  // An owner byte in the terminal-count cycle wins: owner_valid blocks release.
  assign release_timeout = lock_active && !owner_valid &&
                           (idle_cnt_q == CntW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt_q <= '0;
    end else if ((state_q == ARB_LOCKED) && !owner_valid && !release_timeout) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end else begin
      idle_cnt_q <= '0;
    end
  end
`else
  // Only LineTerm releases the lock; TimeoutCycles has no effect in this build.
  assign release_timeout = 1'b0;

  if (TimeoutCycles == 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_idx;
            state_q <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (release_term || release_timeout) begin
            state_q <= ARB_IDLE;
            ptr_q   <= owner_next;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q == ARB_LOCKED);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// Self-checking bench for uart_tx_line_arbiter (NumReq=4, TimeoutCycles=8).
// Requesters are byte queues; a cycle-level reference model applies the
// arbitration rules (rr grant from pointer, line lock, LineTerm release,
// optional idle timeout) and every cycle predicts busy/owner/valid/data/ready.
module tb_uart_tx_line_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;
  localparam logic [7:0]  LF = 8'h0A;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready  = 1'b1;
  logic [1:0]     owner;
  logic           busy;

  uart_tx_line_arbiter #(
    .NumReq        (N),
    .LineTerm      (8'h0A),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_ready_i  (tx_ready),
    .owner_o     (owner),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  q [N][$];
  bit          offering [N];
  bit          gap_en    = 1'b0;
  int unsigned tx_mode   = 0;
  int unsigned enq_total = 0;

  bit          m_busy  = 1'b0;
  int unsigned m_owner = 0;
  int unsigned m_ptr   = 0;
  int unsigned m_cnt   = 0;

  bit          prev_busy = 1'b0;
  bit          s_busy    = 1'b0;
  bit          s_txv     = 1'b0;
  int unsigned grants [$];
  int unsigned sent   [$];
  int unsigned exp_q  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sel 0: grant order, sel 1: delivered byte stream
  task automatic chk_q(input string tag, input bit sel);
    int unsigned n;
    n = sel ? sent.size() : grants.size();
    chk({tag, "_len"}, 32'(n), 32'(exp_q.size()));
    for (int unsigned i = 0; i < n && i < exp_q.size(); i++)
      chk(tag, sel ? sent[i] : grants[i], exp_q[i]);
  endtask

  function automatic logic vbit(input int unsigned r);
    logic [N-1:0] t;
    t = req_valid >> r;
    return t[0];
  endfunction

  function automatic logic [7:0] dbyte(input int unsigned r);
    return 8'(req_data >> (r * 8));
  endfunction

  function automatic int unsigned pending();
    int unsigned s = 0;
    for (int unsigned r = 0; r < N; r++) s += q[r].size();
    return s;
  endfunction

  task automatic refresh();
    logic [N-1:0]   v;
    logic [N*8-1:0] d;
    logic [7:0]     b;
    v = '0;
    d = '0;
    for (int unsigned r = 0; r < N; r++) begin
      if (!offering[r] && q[r].size() > 0)
        offering[r] = gap_en ? ($urandom_range(3) != 0) : 1'b1;
      b = offering[r] ? q[r][0] : 8'($urandom);
      v = v | (N'(offering[r]) << r);
      d = d | ((N*8)'(b) << (r * 8));
    end
    req_valid = v;
    req_data  = d;
  endtask

  task automatic add_byte(input int unsigned r, input logic [7:0] b);
    q[r].push_back(b);
    enq_total++;
  endtask

  task automatic add_line(input int unsigned r, input string s, input bit term);
    for (int i = 0; i < s.len(); i++) add_byte(r, 8'(s[i]));
    if (term) add_byte(r, LF);
    refresh();
  endtask

  task automatic step();
    logic [N-1:0] rdy_s;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] t;
    logic         exp_v;
    bit           found;
    int unsigned  cand;
    @(negedge clk);
    rdy_s = req_ready;
    if (rst) begin
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      s_busy = 1'b0;
      s_txv  = 1'b0;
    end else begin
      exp_v   = m_busy && vbit(m_owner);
      exp_rdy = m_busy ? (N'(tx_ready) << m_owner) : '0;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("owner", 32'(owner), m_owner);
      chk("tx_valid", 32'(tx_valid), 32'(exp_v));
      chk("ready", 32'(req_ready), 32'(exp_rdy));
      if (exp_v) chk("tx_data", 32'(tx_data), 32'(dbyte(m_owner)));
      if (busy && !prev_busy) grants.push_back(32'(owner));
      if (tx_valid && tx_ready) sent.push_back(32'(tx_data));
      s_busy = busy;
      s_txv  = tx_valid;
    end
    prev_busy = s_busy;

    // Reference model: state after this clock edge.
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        cand = (m_ptr + k) % N;
        if (!found && vbit(cand)) begin
          found = 1'b1; m_owner = cand; m_busy = 1'b1; m_cnt = 0;
        end
      end
    end else if (vbit(m_owner)) begin
      m_cnt = 0;
      if (tx_ready && dbyte(m_owner) == LF) begin
        m_busy = 1'b0; m_ptr = (m_owner + 1) % N;
      end
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      if (m_cnt == TO - 1) begin
        m_busy = 1'b0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
      end else begin
        m_cnt++;
      end
`endif
    end

    @(posedge clk);
    #1;
    for (int unsigned r = 0; r < N; r++) begin
      t = rdy_s >> r;
      if (offering[r] && t[0]) begin
        void'(q[r].pop_front());
        offering[r] = 1'b0;
      end
    end
    case (tx_mode)
      1:       tx_ready = ~tx_ready;
      2:       tx_ready = ($urandom_range(2) != 0);
      default: tx_ready = 1'b1;
    endcase
    refresh();
  endtask

  task automatic do_reset();
    grants.delete();
    sent.delete();
    enq_total = 0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while ((pending() != 0 || m_busy || s_busy) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_pending"}, 32'(pending()), 32'd0);
    chk({tag, "_busy_end"}, 32'(s_busy), 32'd0);
    chk({tag, "_count"}, 32'(sent.size()), 32'(enq_total));
  endtask

  initial begin
    int unsigned n;
    int unsigned r;
    int unsigned len;

    for (int unsigned i = 0; i < N; i++) offering[i] = 1'b0;

    // Reset state
    do_reset();
    step();
    chk("reset_busy", 32'(s_busy), 32'd0);
    chk("reset_tx_valid", 32'(s_txv), 32'd0);

    // Single line "Hi\n" from requester 0
    do_reset();
    add_line(0, "Hi", 1'b1);
    drain("single", 50);
    exp_q = {0};
    chk_q("single_grants", 1'b0);
    exp_q = {8'h48, 8'h69, 8'h0A};
    chk_q("single_bytes", 1'b1);

    // Contention req1/req3 from reset, then req0/req2 to probe pointer wrap
    do_reset();
    rst = 1'b1;
    add_line(1, "ab", 1'b1);
    add_line(3, "cd", 1'b1);
    step();
    rst = 1'b0;
    drain("contend", 100);
    add_line(2, "e", 1'b1);
    add_line(0, "f", 1'b1);
    drain("contend2", 100);
    exp_q = {1, 3, 0, 2};
    chk_q("contend_grants", 1'b0);
    exp_q = {8'h61, 8'h62, 8'h0A, 8'h63, 8'h64, 8'h0A, 8'h66, 8'h0A, 8'h65, 8'h0A};
    chk_q("contend_bytes", 1'b1);

    // Backpressure: tx_ready toggles 1010 during a req2 line
    do_reset();
    tx_mode  = 1;
    tx_ready = 1'b1;
    add_line(2, "xyz", 1'b1);
    drain("bp", 100);
    tx_mode = 0;
    exp_q = {8'h78, 8'h79, 8'h7A, 8'h0A};
    chk_q("bp_bytes", 1'b1);

    // Fairness: all four continuously valid with "A\n" lines
    do_reset();
    for (int unsigned k = 0; k < 2; k++)
      for (int unsigned i = 0; i < N; i++) add_line(i, "A", 1'b1);
    drain("fair", 200);
    exp_q = {0, 1, 2, 3, 0, 1, 2, 3};
    chk_q("fair_grants", 1'b0);

    // Reset mid-line: pointer moved to 2 first, reset must return it to 0
    do_reset();
    add_line(1, "Z", 1'b1);
    drain("midrst_pre", 50);
    add_line(0, "pq", 1'b1);
    n = 0;
    while (sent.size() < 3 && n < 20) begin step(); n++; end
    chk("midrst_first_byte", 32'(sent.size()), 32'd3);
    add_line(2, "r", 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("midrst_busy", 32'(s_busy), 32'd0);
    chk("midrst_tx_valid", 32'(s_txv), 32'd0);
    drain("midrst", 100);
    exp_q = {1, 0, 0, 2};
    chk_q("midrst_grants", 1'b0);
    exp_q = {8'h5A, 8'h0A, 8'h70, 8'h71, 8'h0A, 8'h72, 8'h0A};
    chk_q("midrst_bytes", 1'b1);

    // Owner goes silent mid-line while req2 waits
    do_reset();
    add_line(1, "A", 1'b0);
    n = 0;
    while (sent.size() < 1 && n < 20) begin step(); n++; end
    chk("tmo_first_byte", 32'(sent.size()), 32'd1);
    add_line(2, "B", 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    n = 0;
    while (grants.size() < 2 && n < 40) begin step(); n++; end
    // 8 idle cycles, one IDLE cycle, then req2 locked
    chk("tmo_grant_latency", n, 32'd10);
    drain("tmo", 50);
    exp_q = {8'h41, 8'h42, 8'h0A};
    chk_q("tmo_bytes", 1'b1);
`else
    repeat (40) step();
    chk("notmo_grants", 32'(grants.size()), 32'd1);
    chk("notmo_busy", 32'(s_busy), 32'd1);
    add_line(1, "", 1'b1);
    drain("notmo", 50);
    exp_q = {8'h41, 8'h0A, 8'h42, 8'h0A};
    chk_q("notmo_bytes", 1'b1);
`endif
    exp_q = {1, 2};
    chk_q("tmo_grants", 1'b0);

    // Randomized traffic with valid gaps and random backpressure
    do_reset();
    gap_en  = 1'b1;
    tx_mode = 2;
    repeat (500) begin
      if ($urandom_range(5) == 0) begin
        r = $urandom_range(N - 1);
        if (q[r].size() == 0) begin
          len = $urandom_range(4, 1);
          for (int unsigned i = 1; i < len; i++) add_byte(r, 8'($urandom_range(8'h7E, 8'h20)));
          add_byte(r, LF);
          refresh();
        end
      end
      step();
    end
    drain("rand", 4000);
    gap_en  = 1'b0;
    tx_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
